// File: rtl/kernel_lut_server_if.sv
// rtl/kernel_lut_server_if.sv - coefficient load stream, swap strobe and LUT read ports
interface kernel_lut_server_if #(
   parameter int KERNEL_WIDTH      = 71,
   parameter int KERNEL_DATA_WIDTH = 8
);
   localparam int AW = $clog2(KERNEL_WIDTH);

   logic signed [KERNEL_DATA_WIDTH-1:0] axis_kernel_tdata;
   logic                                axis_kernel_tvalid;
   logic                                axis_kernel_tready;
   logic                                axis_kernel_tlast;
   logic                                swap_enable;
   logic [AW-1:0]                       ero_kernel_lut_address;
   logic signed [KERNEL_DATA_WIDTH-1:0] ero_kernel_lut_data;
   logic [AW-1:0]                       dila_kernel_lut_address;
   logic signed [KERNEL_DATA_WIDTH-1:0] dila_kernel_lut_data;

   // Filter stage / coefficient loader side
   modport master (
      output axis_kernel_tdata, axis_kernel_tvalid, axis_kernel_tlast, swap_enable,
             ero_kernel_lut_address, dila_kernel_lut_address,
      input  axis_kernel_tready, ero_kernel_lut_data, dila_kernel_lut_data
   );

   // LUT server side
   modport slave (
      input  axis_kernel_tdata, axis_kernel_tvalid, axis_kernel_tlast, swap_enable,
             ero_kernel_lut_address, dila_kernel_lut_address,
      output axis_kernel_tready, ero_kernel_lut_data, dila_kernel_lut_data
   );
endinterface

// File: rtl/kernel_lut_server.sv
// rtl/kernel_lut_server.sv - double-banked erosion/dilation kernel LUT with safe-point swap (optional KERNEL_LUT_CHECKSUM_EN)
module kernel_lut_server #(
   parameter int KERNEL_WIDTH      = 71,
   parameter int KERNEL_DATA_WIDTH = 8
) (
   input  logic               clk,
   input  logic               areset_n,
   kernel_lut_server_if.slave lut_if,
   output logic               active_bank,
   output logic               load_busy,
   output logic               swap_pending,
   output logic               load_error
`ifdef KERNEL_LUT_CHECKSUM_EN
   ,
   output logic signed [KERNEL_DATA_WIDTH+$clog2(2*KERNEL_WIDTH):0] active_checksum
`endif
);
   localparam int AW = $clog2(KERNEL_WIDTH);
   localparam int IW = $clog2(2*KERNEL_WIDTH);
   localparam int DW = KERNEL_DATA_WIDTH;
   localparam logic [IW-1:0] LAST_BEAT = IW'(2*KERNEL_WIDTH-1);
   localparam logic [IW-1:0] KW_BEAT   = IW'(KERNEL_WIDTH);

   localparam logic [1:0] ST_LOAD  = 2'd0;
   localparam logic [1:0] ST_DRAIN = 2'd1;
   localparam logic [1:0] ST_PEND  = 2'd2;

   logic [1:0]           state_q, state_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic                 bank_q, bank_d;
   logic                 err_q, err_d;
   // [bank][0 = erosion, 1 = dilation][entry]
   logic signed [DW-1:0] lut_q [2][2][KERNEL_WIDTH];
   logic signed [DW-1:0] ero_q, dila_q;
   logic                 hs, wr_en, wr_dila;
   logic [AW-1:0]        wr_addr;

   assign lut_if.axis_kernel_tready = (state_q != ST_PEND);
   assign hs      = lut_if.axis_kernel_tvalid & lut_if.axis_kernel_tready;
   assign wr_en   = hs & (state_q == ST_LOAD);
   assign wr_dila = (idx_q >= KW_BEAT);
   assign wr_addr = wr_dila ? AW'(idx_q - KW_BEAT) : AW'(idx_q);

   // Load framing and bank-swap sequencing
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      bank_d  = bank_q;
      err_d   = err_q;
      case (state_q)
         ST_LOAD: begin
            if (hs) begin
               if (idx_q == LAST_BEAT) begin
                  idx_d = '0;
                  if (lut_if.axis_kernel_tlast) begin
                     err_d   = 1'b0;
                     state_d = ST_PEND;
                  end else begin
                     err_d   = 1'b1;
                     state_d = ST_DRAIN;
                  end
               end else if (lut_if.axis_kernel_tlast) begin
                  err_d = 1'b1;
                  idx_d = '0;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            if (hs && lut_if.axis_kernel_tlast) state_d = ST_LOAD;
         end
         ST_PEND: begin
            if (lut_if.swap_enable) begin
               bank_d  = ~bank_q;
               state_d = ST_LOAD;
            end
         end
         default: state_d = ST_LOAD;
      endcase
   end

   // Control state registers
   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         state_q <= ST_LOAD;
         idx_q   <= '0;
         bank_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         bank_q  <= bank_d;
         err_q   <= err_d;
      end
   end

   // Coefficient banks; loads only ever land in the shadow bank
   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         for (int b = 0; b < 2; b++)
            for (int l = 0; l < 2; l++)
               for (int e = 0; e < KERNEL_WIDTH; e++)
                  lut_q[b][l][e] <= '0;
      end else if (wr_en) begin
         lut_q[~bank_q][wr_dila][wr_addr] <= lut_if.axis_kernel_tdata;
      end
   end

   // Registered reads from the active bank; out-of-range addresses read as zero
   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         ero_q  <= '0;
         dila_q <= '0;
      end else begin
         ero_q  <= (int'(lut_if.ero_kernel_lut_address) < KERNEL_WIDTH)
                   ? lut_q[bank_q][0][lut_if.ero_kernel_lut_address] : '0;
         dila_q <= (int'(lut_if.dila_kernel_lut_address) < KERNEL_WIDTH)
                   ? lut_q[bank_q][1][lut_if.dila_kernel_lut_address] : '0;
      end
   end

   assign lut_if.ero_kernel_lut_data  = ero_q;
   assign lut_if.dila_kernel_lut_data = dila_q;
   assign active_bank  = bank_q;
   assign swap_pending = (state_q == ST_PEND);
   assign load_error   = err_q;
   assign load_busy    = (state_q != ST_LOAD) | (idx_q != '0);

`ifdef KERNEL_LUT_CHECKSUM_EN
   localparam int CW = DW + IW + 1;

   logic signed [CW-1:0] sum_q, sum_d, csum_q, csum_d;
   logic signed [CW-1:0] beat_ext;
   logic                 beat_ok;

   assign beat_ext = {{(CW-DW){lut_if.axis_kernel_tdata[DW-1]}}, lut_if.axis_kernel_tdata};
   // A beat keeps the set alive only when tlast coincides exactly with the final beat index
   assign beat_ok  = (lut_if.axis_kernel_tlast == (idx_q == LAST_BEAT));

   // Running sum of the shadow set, published when the banks swap
   always_comb begin
      sum_d  = sum_q;
      csum_d = csum_q;
      if (wr_en) begin
         sum_d = beat_ok ? sum_q + beat_ext : '0;
      end else if (state_q == ST_PEND && lut_if.swap_enable) begin
         csum_d = sum_q;
         sum_d  = '0;
      end
   end

   // Checksum registers
   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         sum_q  <= '0;
         csum_q <= '0;
      end else begin
         sum_q  <= sum_d;
         csum_q <= csum_d;
      end
   end

   assign active_checksum = csum_q;
`endif
endmodule

// File: tb/tb_kernel_lut_server.sv
// tb/tb_kernel_lut_server.sv - directed scoreboard bench for kernel_lut_server
module tb_kernel_lut_server;
   localparam int KW = 71;
   localparam int DW = 8;
   localparam int AW = $clog2(KW);

   logic clk = 1'b0;
   logic areset_n = 1'b0;
   logic active_bank, load_busy, swap_pending, load_error;
`ifdef KERNEL_LUT_CHECKSUM_EN
   logic signed [DW+$clog2(2*KW):0] active_checksum;
`endif

   int checks = 0;
   int failures = 0;

   logic signed [31:0] exp_ero [KW];
   logic signed [31:0] exp_dila [KW];
   logic signed [31:0] pend_ero [KW];
   logic signed [31:0] pend_dila [KW];
   logic signed [31:0] pend_sum, act_sum;
   logic signed [31:0] q_ero [$];
   logic signed [31:0] q_dila [$];
   int model_bank;

   kernel_lut_server_if #(.KERNEL_WIDTH(KW), .KERNEL_DATA_WIDTH(DW)) bus ();

   kernel_lut_server #(.KERNEL_WIDTH(KW), .KERNEL_DATA_WIDTH(DW)) dut (
      .clk          (clk),
      .areset_n     (areset_n),
      .lut_if       (bus),
      .active_bank  (active_bank),
      .load_busy    (load_busy),
      .swap_pending (swap_pending),
      .load_error   (load_error)
`ifdef KERNEL_LUT_CHECKSUM_EN
      ,
      .active_checksum (active_checksum)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] req);
      checks++;
      assert (obs === req) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic signed [31:0] beat_val(input int kind, input int i);
      case (kind)
         0:       return (i < KW) ? i - 35 : 35 - (i - KW);
         1:       return 1;
         default: return ((i * 37 + 11) % 256) - 128;
      endcase
   endfunction

   task automatic clear_model();
      for (int i = 0; i < KW; i++) begin
         exp_ero[i] = 0; exp_dila[i] = 0; pend_ero[i] = 0; pend_dila[i] = 0;
      end
      pend_sum = 0; act_sum = 0; model_bank = 0;
      q_ero.delete(); q_dila.delete();
   endtask

   task automatic fill_pend(input int kind);
      pend_sum = 0;
      for (int i = 0; i < KW; i++) begin
         pend_ero[i]  = beat_val(kind, i);
         pend_dila[i] = beat_val(kind, i + KW);
         pend_sum     = pend_sum + pend_ero[i] + pend_dila[i];
      end
   endtask

   task automatic status(input string pfx, input int bank, input int busy, input int pend,
                         input int err, input int ready);
      check({pfx, "_active_bank"}, active_bank, bank);
      check({pfx, "_load_busy"}, load_busy, busy);
      check({pfx, "_swap_pending"}, swap_pending, pend);
      check({pfx, "_load_error"}, load_error, err);
      check({pfx, "_tready"}, bus.axis_kernel_tready, ready);
   endtask

   task automatic rd(input int ea, input int da);
      bus.ero_kernel_lut_address  = AW'(ea);
      bus.dila_kernel_lut_address = AW'(da);
      q_ero.push_back((ea < KW) ? exp_ero[ea] : 0);
      q_dila.push_back((da < KW) ? exp_dila[da] : 0);
      tick();
      check($sformatf("ero_data_a%0d", ea), bus.ero_kernel_lut_data, q_ero.pop_front());
      check($sformatf("dila_data_a%0d", da), bus.dila_kernel_lut_data, q_dila.pop_front());
   endtask

   task automatic load(input int kind, input int nbeats, input int tlast_at);
      for (int i = 0; i < nbeats; i++) begin
         bus.axis_kernel_tvalid = 1'b1;
         bus.axis_kernel_tdata  = DW'(beat_val(kind, i));
         bus.axis_kernel_tlast  = (i == tlast_at);
         if (i == 0) check("tready_first_beat", bus.axis_kernel_tready, 1);
         tick();
      end
      bus.axis_kernel_tvalid = 1'b0;
      bus.axis_kernel_tlast  = 1'b0;
   endtask

   // Swap with a read issued in the swap cycle: that read must still see the old bank
   task automatic do_swap();
      bus.swap_enable = 1'b1;
      rd(5, 5);
      bus.swap_enable = 1'b0;
      for (int i = 0; i < KW; i++) begin
         exp_ero[i]  = pend_ero[i];
         exp_dila[i] = pend_dila[i];
      end
      act_sum    = pend_sum;
      model_bank = 1 - model_bank;
      check("bank_after_swap", active_bank, model_bank);
`ifdef KERNEL_LUT_CHECKSUM_EN
      check("checksum_after_swap", active_checksum, act_sum);
`endif
   endtask

   task automatic do_reset(input string pfx);
      @(posedge clk);
      #2 areset_n = 1'b0;
      #1;
      clear_model();
      status(pfx, 0, 0, 0, 0, 1);
      check({pfx, "_ero_data"}, bus.ero_kernel_lut_data, 0);
      check({pfx, "_dila_data"}, bus.dila_kernel_lut_data, 0);
`ifdef KERNEL_LUT_CHECKSUM_EN
      check({pfx, "_checksum"}, active_checksum, 0);
`endif
      @(negedge clk);
      areset_n = 1'b1;
   endtask

   initial begin
      bus.axis_kernel_tvalid      = 1'b0;
      bus.axis_kernel_tdata       = '0;
      bus.axis_kernel_tlast       = 1'b0;
      bus.swap_enable             = 1'b0;
      bus.ero_kernel_lut_address  = '0;
      bus.dila_kernel_lut_address = '0;
      clear_model();
      repeat (3) @(negedge clk);
      areset_n = 1'b1;

      // Reset state and flat kernel
      status("reset", 0, 0, 0, 0, 1);
      rd(0, 70);

      // First clean load, held pending until the safe point
      load(0, 142, 141);
      fill_pend(0);
      status("pending1", 0, 1, 1, 0, 0);
      rd(5, 5);
      do_swap();
      status("swapped1", 1, 0, 0, 0, 1);
      rd(5, 0);
      rd(0, 5);
      rd(70, 70);
      for (int a = 71; a < 128; a += 28) rd(a, a);
      rd(127, 127);

      // swap_enable outside PENDING is ignored
      bus.swap_enable = 1'b1;
      tick();
      bus.swap_enable = 1'b0;
      check("ignored_swap_bank", active_bank, 1);

      // Early tlast: framing error, nothing committed
      load(2, 11, 10);
      status("early_tlast", 1, 0, 0, 1, 1);
      bus.swap_enable = 1'b1;
      tick();
      bus.swap_enable = 1'b0;
      check("no_swap_after_error", active_bank, 1);
      rd(5, 5);

      // Clean all-ones load clears the error
      load(1, 142, 141);
      fill_pend(1);
      status("pending2", 1, 1, 1, 0, 0);
      do_swap();
      rd(3, 3);
      rd(70, 0);

      // Overrun without tlast, then drain three extra beats
      load(0, 142, -1);
      status("draining", 0, 1, 0, 1, 1);
      load(2, 3, 2);
      status("drained", 0, 0, 0, 1, 1);
      rd(3, 69);

      // Reset in the middle of a load
      load(0, 60, -1);
      check("midload_busy", load_busy, 1);
      do_reset("reset_midload");
      rd(3, 70);

      // Reset while a complete set is pending
      load(0, 142, 141);
      check("pend3_swap_pending", swap_pending, 1);
      do_reset("reset_pending");
      rd(5, 5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
